// File: rtl/elixirchip_es1_spu_op_mem_reader.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_mem_reader
//
// Read-side initiator for elixirchip_es1_spu_op_mem. A burst command
// (start address, beats-minus-one) is turned into one read address per cycle
// on the memory read port. The fixed-latency read data is re-timed through a
// {valid,last} pipe and written into a small output FIFO. The FIFO is
// presented as a valid/ready stream with a last flag.
//
// Parameters:
//   RLATENCY   memory read latency in cke-enabled cycles (must match the mem)
//   DATA_BITS  data width
//   ADDR_BITS  address width
//   MEM_SIZE   address space; addresses wrap modulo MEM_SIZE
//   LEN_BITS   burst length field width
//   FIFO_DEPTH output FIFO depth (>= 2)
//
// Ports:
//   clk, reset (async, active-low), cke (global clock enable, mem shares it)
//   s_cmd_addr/s_cmd_len/s_cmd_valid/s_cmd_ready : burst command input
//   m_raddr/m_rvalid                             : to mem read port
//   s_rdata                                      : from mem read data
//   m_data/m_last/m_valid/m_ready                : output stream
//   stall_count                                  : credit-stall cycle counter
//
// Handshakes: a transfer happens on a rising clk edge where cke=1 and both
// valid and ready are high. valid never depends on ready; once the output
// stream raises m_valid, m_data/m_last hold until the transfer happens.
//
// Configuration macro: ELIXIRCHIP_ES1_SPU_OP_MEM_READER_STALL_CNT_EN
//   defined   -> stall_count counts cke cycles in READ with no credit (saturating)
//   undefined -> stall_count is tied to 0
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_mem_reader #(
  parameter int RLATENCY   = 2,
  parameter int DATA_BITS  = 18,
  parameter int ADDR_BITS  = 10,
  parameter int MEM_SIZE   = 2 ** ADDR_BITS,
  parameter int LEN_BITS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [ADDR_BITS-1:0] s_cmd_addr,
  input  logic [LEN_BITS-1:0]  s_cmd_len,
  input  logic                 s_cmd_valid,
  output logic                 s_cmd_ready,
  output logic [ADDR_BITS-1:0] m_raddr,
  output logic                 m_rvalid,
  input  logic [DATA_BITS-1:0] s_rdata,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          stall_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0]        DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]        PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = ADDR_BITS'(MEM_SIZE - 1);

  generate
    if (FIFO_DEPTH < 2) begin : g_bad_depth
      $error("FIFO_DEPTH must be at least 2");
    end
    if (RLATENCY < 1) begin : g_bad_latency
      $error("RLATENCY must be at least 1");
    end
  endgenerate

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [LEN_BITS-1:0]    remain_q;
  logic [CW-1:0]          credit_q;
  logic [CW-1:0]          credit_d;

  logic                   m_rvalid_q;
  logic                   m_rlast_q;
  logic [ADDR_BITS-1:0]   m_raddr_q;

  logic [RLATENCY-1:0]    pipe_valid_q;
  logic [RLATENCY-1:0]    pipe_last_q;

  logic [DATA_BITS-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last_q;
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [PW-1:0]          wr_ptr_d;
  logic [PW-1:0]          rd_ptr_d;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   credit_ok;
  logic                   issue;
  logic                   last_beat;
  logic [ADDR_BITS-1:0]   cur_addr;
  logic [LEN_BITS-1:0]    cur_remain;
  logic [ADDR_BITS-1:0]   next_addr;

  always_comb begin
    accept     = 1'b0;
    pop        = 1'b0;
    push       = 1'b0;
    credit_ok  = 1'b0;
    issue      = 1'b0;
    last_beat  = 1'b0;
    cur_addr   = addr_q;
    cur_remain = remain_q;
    next_addr  = '0;
    credit_d   = credit_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    accept = cke && (state_q == ST_IDLE) && s_cmd_valid;

    // The accepting edge already issues the first beat, so the address and
    // length come straight from the command in IDLE.
    if (state_q == ST_IDLE) begin
      cur_addr   = s_cmd_addr;
      cur_remain = s_cmd_len;
    end

    pop  = cke && (count_q != '0) && m_ready;
    push = cke && pipe_valid_q[RLATENCY-1];

    // A pop on the same edge frees a slot; counting it lets a FIFO of
    // RLATENCY+2 sustain one beat per cycle.
    credit_ok = (credit_q < DEPTH_C) || pop;
    issue     = credit_ok && (accept || (cke && (state_q == ST_READ)));
    last_beat = (cur_remain == '0);

    next_addr = (cur_addr == ADDR_LAST) ? '0 : cur_addr + 1'b1;

    credit_d = credit_q + CW'(issue) - CW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue FSM with registered read-port outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      m_rvalid_q <= 1'b0;
      m_rlast_q  <= 1'b0;
      m_raddr_q  <= '0;
    end else if (cke) begin
      if (issue) begin
        m_rvalid_q <= 1'b1;
        m_raddr_q  <= cur_addr;
        m_rlast_q  <= last_beat;
        addr_q     <= next_addr;
        remain_q   <= cur_remain - 1'b1;
        state_q    <= last_beat ? ST_IDLE : ST_READ;
      end else begin
        m_rvalid_q <= 1'b0;
        if (accept) begin
          // Accepted with no credit: hold the command and wait in READ.
          addr_q   <= s_cmd_addr;
          remain_q <= s_cmd_len;
          state_q  <= ST_READ;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter and latency pipe
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_q     <= '0;
      pipe_valid_q <= '0;
      pipe_last_q  <= '0;
    end else if (cke) begin
      credit_q        <= credit_d;
      pipe_valid_q[0] <= m_rvalid_q;
      pipe_last_q[0]  <= m_rlast_q;
      for (int i = RLATENCY - 1; i > 0; i--) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_last_q[i]  <= pipe_last_q[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO (credit guarantees it is never written while full)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else if (cke) begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= s_rdata;
        fifo_last_q[wr_ptr_q] <= pipe_last_q[RLATENCY-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------------
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (cke && (state_q == ST_READ) && !issue && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 32'd0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_cmd_ready = (state_q == ST_IDLE);
  assign m_rvalid    = m_rvalid_q;
  assign m_raddr     = m_raddr_q;
  assign m_valid     = (count_q != '0);
  assign m_data      = fifo_data_q[rd_ptr_q];
  assign m_last      = fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_elixirchip_es1_spu_op_mem_reader.sv
// -----------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_mem_reader
//
// Bench for the op-mem read initiator. A behavioural memory with RLATENCY
// cke-cycle latency feeds the DUT. Each accepted command expands into its
// expected address list and expected {last,data} beats; one monitor compares
// every issued address and every delivered beat against those queues.
// -----------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_mem_reader;

  localparam int RLATENCY   = 2;
  localparam int DATA_BITS  = 18;
  localparam int ADDR_BITS  = 10;
  localparam int MEM_SIZE   = 2 ** ADDR_BITS;
  localparam int LEN_BITS   = 8;
  localparam int FIFO_DEPTH = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic                 clk;
  logic                 reset;
  logic                 cke;
  logic [ADDR_BITS-1:0] s_cmd_addr;
  logic [LEN_BITS-1:0]  s_cmd_len;
  logic                 s_cmd_valid;
  logic                 s_cmd_ready;
  logic [ADDR_BITS-1:0] m_raddr;
  logic                 m_rvalid;
  logic [DATA_BITS-1:0] s_rdata;
  logic [DATA_BITS-1:0] m_data;
  logic                 m_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [31:0]          stall_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  elixirchip_es1_spu_op_mem_reader #(
    .RLATENCY  (RLATENCY),
    .DATA_BITS (DATA_BITS),
    .ADDR_BITS (ADDR_BITS),
    .MEM_SIZE  (MEM_SIZE),
    .LEN_BITS  (LEN_BITS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cke        (cke),
    .s_cmd_addr (s_cmd_addr),
    .s_cmd_len  (s_cmd_len),
    .s_cmd_valid(s_cmd_valid),
    .s_cmd_ready(s_cmd_ready),
    .m_raddr    (m_raddr),
    .m_rvalid   (m_rvalid),
    .s_rdata    (s_rdata),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .stall_count(stall_count)
  );

  // ---------------------------------------------------------------------------
  // Behavioural memory: address sampled on a cke edge, data visible RLATENCY
  // cke edges later.
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem_arr [MEM_SIZE];
  logic [DATA_BITS-1:0] mpipe   [RLATENCY];

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem_arr[i] = DATA_BITS'($urandom);
    for (int i = 0; i < RLATENCY; i++) mpipe[i] = '0;
  end

  always @(posedge clk) begin
    if (cke) begin
      mpipe[0] <= mem_arr[m_raddr];
      for (int i = 1; i < RLATENCY; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign s_rdata = mpipe[RLATENCY-1];

  // ---------------------------------------------------------------------------
  // Scoreboard state and check helper
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [DATA_BITS:0]   exp_q  [$];
  logic [ADDR_BITS-1:0] addr_q [$];
  int                   issue_stamp [$];
  int                   pop_stamp   [$];
  int                   outstanding = 0;
  logic [DATA_BITS:0]   exp_beat;
  logic                 hold_pending = 1'b0;
  logic [DATA_BITS:0]   hold_val;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: sampled at the falling edge, describing what the next rising
  // edge will transfer.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      addr_q.delete();
      outstanding  = 0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && m_valid) check("hold_stable", {m_last, m_data}, hold_val);
      if (cke) begin
        if (s_cmd_valid && s_cmd_ready) begin
          for (int i = 0; i <= int'(s_cmd_len); i++) begin
            int a;
            a = (int'(s_cmd_addr) + i) % MEM_SIZE;
            addr_q.push_back(ADDR_BITS'(a));
            exp_q.push_back({(i == int'(s_cmd_len)), mem_arr[a]});
          end
        end
        if (m_rvalid) begin
          if (addr_q.size() == 0) check("unexpected_issue", 64'd1, 64'd0);
          else check("raddr", m_raddr, addr_q.pop_front());
          outstanding++;
          issue_stamp.push_back(cyc);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 64'd1, 64'd0);
          end else begin
            exp_beat = exp_q.pop_front();
            check("beat_data", m_data, exp_beat[DATA_BITS-1:0]);
            check("beat_last", m_last, exp_beat[DATA_BITS]);
          end
          outstanding--;
          pop_stamp.push_back(cyc);
        end
        check("credit_bound", (outstanding <= FIFO_DEPTH), 64'd1);
      end
      hold_pending = m_valid && !(m_ready && cke);
      hold_val     = {m_last, m_data};
    end
  end

  // ---------------------------------------------------------------------------
  // Background driver for cke and m_ready (fixed or random per mode)
  // ---------------------------------------------------------------------------
  logic rand_cke   = 1'b0;
  logic rand_ready = 1'b0;
  logic cke_fix    = 1'b1;
  logic ready_fix  = 1'b1;

  initial begin
    cke     = 1'b1;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cke     = rand_cke   ? ($urandom_range(0, 3) != 0) : cke_fix;
      m_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Returns #1 after the accepting edge.
  task automatic send_cmd(input logic [ADDR_BITS-1:0] a, input logic [LEN_BITS-1:0] l);
    bit done = 0;
    s_cmd_addr  = a;
    s_cmd_len   = l;
    s_cmd_valid = 1'b1;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (s_cmd_ready && cke) done = 1;
      @(posedge clk);
      #1;
    end
    s_cmd_valid = 1'b0;
    if (!done) check("cmd_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && addr_q.size() == 0 && s_cmd_ready && !m_valid) done = 1;
    end
    if (!done) check("drain_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    check("rst_cmd_ready", s_cmd_ready, 64'd1);
    check("rst_rvalid",    m_rvalid,    64'd0);
    check("rst_raddr",     m_raddr,     64'd0);
    check("rst_valid",     m_valid,     64'd0);
    check("rst_data",      m_data,      64'd0);
    check("rst_last",      m_last,      64'd0);
    check("rst_stall",     stall_count, 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    logic [31:0] st0;

    s_cmd_addr  = '0;
    s_cmd_len   = '0;
    s_cmd_valid = 1'b0;
    reset       = 1'b1;
    #1 reset    = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: first address right after the accept edge, data 3 edges later.
    send_cmd(10'd5, 8'd0);
    check("one_rvalid", m_rvalid, 64'd1);
    check("one_raddr",  m_raddr,  64'd5);
    n = 0;
    while (!m_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("one_latency", n, 64'd3);
    check("one_data", m_data, mem_arr[5]);
    check("one_last", m_last, 64'd1);
    wait_drain();

    // 8-beat burst at full rate.
    issue_stamp.delete();
    pop_stamp.delete();
    send_cmd(10'd0, 8'd7);
    wait_drain();
    check("burst_issues", issue_stamp.size(), 64'd8);
    check("burst_beats",  pop_stamp.size(),   64'd8);
    if (issue_stamp.size() == 8) check("burst_issue_rate", issue_stamp[7] - issue_stamp[0], 64'd7);
    if (pop_stamp.size() == 8)   check("burst_beat_rate",  pop_stamp[7] - pop_stamp[0],     64'd7);

    // Address wrap.
    issue_stamp.delete();
    send_cmd(10'(MEM_SIZE - 2), 8'd3);
    wait_drain();
    check("wrap_issues", issue_stamp.size(), 64'd4);

    // Backpressure: only FIFO_DEPTH reads go out while nothing is drained.
    ready_fix = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    st0 = stall_count;
    issue_stamp.delete();
    pop_stamp.delete();
    send_cmd(10'h100, 8'd15);
    repeat (20) @(posedge clk);
    #2;
    check("bp_issues", issue_stamp.size(), 64'd4);
    check("bp_rvalid_low", m_rvalid, 64'd0);
    check("bp_valid_high", m_valid, 64'd1);
`ifdef ELIXIRCHIP_ES1_SPU_OP_MEM_READER_STALL_CNT_EN
    check("bp_stall_grows", (stall_count - st0) >= 32'd15, 64'd1);
`else
    check("bp_stall_zero", stall_count, 64'd0);
`endif
    ready_fix = 1'b1;
    wait_drain();
    check("bp_beats", pop_stamp.size(), 64'd16);

    // cke gaps with random backpressure.
    pop_stamp.delete();
    rand_cke   = 1'b1;
    rand_ready = 1'b1;
    send_cmd(10'h030, 8'd9);
    wait_drain();
    check("cke_beats", pop_stamp.size(), 64'd10);

    // Random command stream, back-to-back, including a maximum-length burst.
    pop_stamp.delete();
    n = 0;
    for (int k = 0; k < 6; k++) begin
      logic [LEN_BITS-1:0] l;
      l = LEN_BITS'($urandom_range(0, 20));
      n += int'(l) + 1;
      send_cmd(ADDR_BITS'($urandom_range(0, MEM_SIZE - 1)), l);
    end
    send_cmd(10'd1000, 8'd255);
    n += 256;
    wait_drain();
    check("rand_beats", pop_stamp.size(), n);
    rand_cke   = 1'b0;
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a burst.
    issue_stamp.delete();
    send_cmd(10'h200, 8'd15);
    n = 0;
    while (issue_stamp.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_issue_count", issue_stamp.size(), 64'd3);
    #1 reset = 1'b0;
    #1;
    check_reset_values();
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_no_beat", m_valid, 64'd0);
    pop_stamp.delete();
    send_cmd(10'd20, 8'd0);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_beats", pop_stamp.size(), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
